uart_tx_frame: RTL
==================

# uart_tx_frame

Transmit half of the UART interface: accepts a parallel data word with a one-cycle valid strobe and serialises it onto a single line as start bit, data bits LSB-first, optional parity bit, and stop bit. CLK runs at the bit rate, so each frame bit is held for exactly one CLK cycle. The receive side oversamples the same line at Prescale × bit rate. Contains the frame FSM, serializer/bit counter, parity generator and output mux.

## Interface

- DATA_WIDTH, 8, number of data bits per frame; bit counter is clog2(DATA_WIDTH) bits wide.
- CLK  input  1  bit-rate clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel word to send; sampled only when accepted.
- Data_Valid  input  1  request strobe; accepted only in IDLE.
- PAR_EN  input  1  1 = include parity bit; sampled with P_DATA.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled with P_DATA.
- TX_OUT  output  1  serial line, registered, idle-high.
- Busy  output  1  registered; 1 while a frame occupies the line.

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset: state IDLE, TX_OUT = 1, Busy = 0, bit counter = 0, data/parity registers = 0. Takes effect immediately, including mid-frame. There is no partial-frame recovery.
- IDLE: TX_OUT = 1, Busy = 0. If Data_Valid = 1 at a rising edge:
  - latch P_DATA, PAR_EN and PAR_TYP;
  - compute parity bit = (^P_DATA) XOR PAR_TYP;
  - go to START.
- START: TX_OUT = 0, Busy = 1. Next state is DATA, with bit counter = 0.
- DATA: TX_OUT = latched_data[bit counter]. The counter increments each cycle.
  - At counter = DATA_WIDTH-1, go to PARITY if latched PAR_EN = 1, else STOP.
  - The counter clears on leaving DATA.
- PARITY: TX_OUT = latched parity bit. Next state is STOP.
- STOP: TX_OUT = 1, Busy = 1. Next state is IDLE.
- Data_Valid in any state other than IDLE is ignored. P_DATA, PAR_EN and PAR_TYP may change freely after acceptance without affecting the frame in flight.
- Data_Valid held high continuously starts a new frame on each pass through IDLE. It is not treated as a level "hold" request.
- Parity arithmetic: even parity makes the total count of ones (data + parity) even. Odd parity makes it odd.

## Timing

- Acceptance at edge N: TX_OUT = 0 and Busy = 1 are visible after edge N. Latency from strobe to start bit is 1 cycle.
- Frame duration with Busy = 1:
  - DATA_WIDTH + 2 cycles without parity (10 for default);
  - DATA_WIDTH + 3 cycles with parity (11).
- Data bit i is on TX_OUT during cycle i+2 of the frame, counting the start bit as cycle 1.
- Busy falls at the edge that leaves STOP. TX_OUT stays 1.
- Minimum inter-frame gap is 1 idle cycle, because the strobe is sampled in IDLE. Back-to-back throughput is therefore 1 frame per DATA_WIDTH+3 (or +4) cycles.
- TX_OUT and Busy are glitch-free register outputs with no combinational path from any input.
- Async reset assertion forces TX_OUT = 1 and Busy = 0 within the same cycle. Deassertion is synchronised externally.

## Test plan

- Reset then idle: hold RST = 0 for 3 cycles, then release with Data_Valid = 0 for 20 cycles. Required: TX_OUT = 1 and Busy = 0 throughout.
- P_DATA = 0xA5, PAR_EN = 0, one-cycle strobe. Required: TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; Busy high for exactly 10 cycles.
- P_DATA = 0x3C, PAR_EN = 1, PAR_TYP = 0 → parity bit 0. Repeat with PAR_TYP = 1 → parity bit 1. P_DATA = 0x01, PAR_TYP = 1 → parity bit 0. Busy is 11 cycles each time.
- Strobe with 0x55, then pulse Data_Valid with 0xFF during DATA and during STOP. Required: 0x55 frame unchanged, 0xFF never sent, Busy drops after 10 cycles.
- Data_Valid held high with constant 0x81, PAR_EN = 0. Required: frames repeat every 11 cycles with exactly one TX_OUT = 1, Busy = 0 idle cycle between them.
- Assert RST during data bit 4 of a 0x00 frame, release, then strobe 0xF0. Required: TX_OUT = 1 and Busy = 0 immediately on reset; the following frame is a clean start, 0,0,0,0,1,1,1,1, then stop.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer. Serialises a parallel word as
// start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit and
// stop bit (1). CLK runs at the bit rate, so each frame bit lasts one cycle.
//
// Ports:
//   CLK        bit-rate clock, rising edge
//   RST        asynchronous active-low reset
//   P_DATA     parallel word, sampled when accepted in IDLE
//   Data_Valid request strobe, honoured only in IDLE
//   PAR_EN     1 = append parity bit (sampled with P_DATA)
//   PAR_TYP    0 = even, 1 = odd parity (sampled with P_DATA)
//   TX_OUT     registered serial line, idle-high
//   Busy       registered, high while a frame occupies the line
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  par_en_q, par_en_n;
  logic                  par_q, par_n;
  logic                  tx_n, busy_n;

  // State, datapath and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      data_q   <= data_n;
      par_en_q <= par_en_n;
      par_q    <= par_n;
      TX_OUT   <= tx_n;
      Busy     <= busy_n;
    end
  end

  // Next-state logic; outputs are decoded from the next state so the
  // registered line shows each bit in the cycle its state is occupied.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    data_n   = data_q;
    par_en_n = par_en_q;
    par_n    = par_q;
    tx_n     = 1'b1;
    busy_n   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          data_n   = P_DATA;
          par_en_n = PAR_EN;
          par_n    = (^P_DATA) ^ PAR_TYP;
          state_n  = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = DATA;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_n   = '0;
          state_n = par_en_q ? PARITY : STOP;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      PARITY:  state_n = STOP;
      STOP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    case (state_n)
      START: begin
        tx_n   = 1'b0;
        busy_n = 1'b1;
      end
      DATA: begin
        tx_n   = data_n[cnt_n];
        busy_n = 1'b1;
      end
      PARITY: begin
        tx_n   = par_n;
        busy_n = 1'b1;
      end
      STOP: begin
        tx_n   = 1'b1;
        busy_n = 1'b1;
      end
      default: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
      end
    endcase
  end

endmodule
